// File: rtl/operand_register_file_pkg.sv
// Shared types and constants for the operand register file: FunSel operations,
// read-port source encodings and the default data width.
package operand_rf_pkg;

  localparam int WIDTH = 32;

  typedef enum logic [2:0] {
    RF_DEC  = 3'b000,
    RF_INC  = 3'b001,
    RF_LOAD = 3'b010,
    RF_CLR  = 3'b011,
    RF_LDB  = 3'b100,
    RF_LDH  = 3'b101,
    RF_SHB  = 3'b110,
    RF_SXH  = 3'b111
  } rf_fun_e;

  localparam logic [2:0] SEL_R1 = 3'b000;
  localparam logic [2:0] SEL_R2 = 3'b001;
  localparam logic [2:0] SEL_R3 = 3'b010;
  localparam logic [2:0] SEL_R4 = 3'b011;
  localparam logic [2:0] SEL_S1 = 3'b100;
  localparam logic [2:0] SEL_S2 = 3'b101;
  localparam logic [2:0] SEL_S3 = 3'b110;
  localparam logic [2:0] SEL_S4 = 3'b111;

endpackage

// File: rtl/operand_register_file_if.sv
// Write/select/read bundle between the datapath controller (master) and the
// operand register file (slave).
interface operand_register_file_if
  import operand_rf_pkg::*;
#(
  parameter int W = WIDTH
);
  logic [W-1:0] I;
  logic [2:0]   FunSel;
  logic [3:0]   RegSel;
  logic [3:0]   ScrSel;
  logic [2:0]   OutASel;
  logic [2:0]   OutBSel;
  logic [W-1:0] OutA;
  logic [W-1:0] OutB;

  modport master (
    output I, FunSel, RegSel, ScrSel, OutASel, OutBSel,
    input  OutA, OutB
  );

  modport slave (
    input  I, FunSel, RegSel, ScrSel, OutASel, OutBSel,
    output OutA, OutB
  );
endinterface

// File: rtl/operand_register_file_reg.sv
// operand_reg: one operand register applying the selected FunSel operation
// when enabled, holding otherwise.
module operand_reg
  import operand_rf_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic         Clock,
  input  logic         Reset_N,
  input  logic         enable,
  input  rf_fun_e      FunSel,
  input  logic [W-1:0] I,
  output logic [W-1:0] Q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (enable) begin
      case (FunSel)
        RF_DEC:  q_d = q_q - W'(1);
        RF_INC:  q_d = q_q + W'(1);
        RF_LOAD: q_d = I;
        RF_CLR:  q_d = '0;
        RF_LDB:  q_d = {{(W-8){1'b0}}, I[7:0]};
        RF_LDH:  q_d = {q_q[W-1:16], I[15:0]};
        RF_SHB:  q_d = {q_q[W-9:0], I[7:0]};
        RF_SXH:  q_d = {{(W-16){I[15]}}, I[15:0]};
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset_N) begin
    if (!Reset_N) q_q <= '0;
    else          q_q <= q_d;
  end

  assign Q = q_q;

endmodule

// File: rtl/operand_register_file.sv
// Operand register file: R1-R4 plus optional scratch S1-S4 (OPERAND_RF_SCRATCH_EN)
// with two combinational read ports feeding ALU operands A and B.
module operand_register_file
  import operand_rf_pkg::*;
(
  input  logic                    Clock,
  input  logic                    Reset_N,
  operand_register_file_if.slave  bus
);

  rf_fun_e          fun_sel;
  logic [WIDTH-1:0] rd_val [8];

  assign fun_sel = rf_fun_e'(bus.FunSel);

  // Select bit 3 addresses the first register of each bank.
  for (genvar g = 0; g < 4; g++) begin : g_gen_r
    operand_reg #(.W(WIDTH)) u_r (
      .Clock   (Clock),
      .Reset_N (Reset_N),
      .enable  (bus.RegSel[3-g]),
      .FunSel  (fun_sel),
      .I       (bus.I),
      .Q       (rd_val[g])
    );
  end

`ifdef OPERAND_RF_SCRATCH_EN
  for (genvar g = 0; g < 4; g++) begin : g_gen_s
    operand_reg #(.W(WIDTH)) u_s (
      .Clock   (Clock),
      .Reset_N (Reset_N),
      .enable  (bus.ScrSel[3-g]),
      .FunSel  (fun_sel),
      .I       (bus.I),
      .Q       (rd_val[4+g])
    );
  end
`else
  logic unused_scr_sel;
  assign unused_scr_sel = ^bus.ScrSel;
  for (genvar g = 0; g < 4; g++) begin : g_gen_s_off
    assign rd_val[4+g] = '0;
  end
`endif

  assign bus.OutA = rd_val[bus.OutASel];
  assign bus.OutB = rd_val[bus.OutBSel];

endmodule

// File: tb/tb_operand_register_file.sv
// Directed self-checking bench for operand_register_file; scratch expectations
// follow whether OPERAND_RF_SCRATCH_EN is defined for the build.
module tb_operand_register_file;
  import operand_rf_pkg::*;

  logic Clock;
  logic Reset_N;
  int   checkCount;
  int   passCount;
  logic [31:0] expRegs [8];

  operand_register_file_if #(.W(32)) bus ();

  operand_register_file dut (
    .Clock   (Clock),
    .Reset_N (Reset_N),
    .bus     (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
  endtask

  // One write cycle: drive at the falling edge, let the rising edge commit, then deselect.
  task automatic applyStimulus(input logic [2:0] fun, input logic [3:0] rsel,
                               input logic [3:0] ssel, input logic [31:0] data);
    @(negedge Clock);
    bus.FunSel = fun;
    bus.RegSel = rsel;
    bus.ScrSel = ssel;
    bus.I      = data;
    @(posedge Clock);
    #1;
    bus.RegSel = 4'b0000;
    bus.ScrSel = 4'b0000;
  endtask

  task automatic checkReg(input string tag, input logic [2:0] sel, input logic [31:0] expected);
    bus.OutASel = sel;
    #1;
    checkOutput(tag, bus.OutA, expected);
  endtask

  // Reads all eight sources, port B walking in the opposite order to port A.
  task automatic checkAll(input string tag);
    for (int i = 0; i < 8; i++) begin
      bus.OutASel = 3'(i);
      bus.OutBSel = 3'(7 - i);
      #1;
      checkOutput($sformatf("%s_A%0d", tag, i), bus.OutA, expRegs[i]);
      checkOutput($sformatf("%s_B%0d", tag, 7 - i), bus.OutB, expRegs[7 - i]);
    end
  endtask

  initial begin
    checkCount  = 0;
    passCount   = 0;
    Reset_N     = 1'b0;
    bus.I       = '0;
    bus.FunSel  = RF_CLR;
    bus.RegSel  = 4'b0000;
    bus.ScrSel  = 4'b0000;
    bus.OutASel = SEL_R1;
    bus.OutBSel = SEL_R1;
    for (int i = 0; i < 8; i++) expRegs[i] = 32'h0;

    #12;
    Reset_N = 1'b1;
    #1;
    checkAll("reset");

    // Asynchronous reset mid-cycle, then reset overriding a concurrent write.
    applyStimulus(RF_LOAD, 4'b1000, 4'b0000, 32'h12345678);
    checkReg("r1_load", SEL_R1, 32'h12345678);
    @(negedge Clock);
    #2;
    Reset_N = 1'b0;
    #1;
    checkOutput("async_reset_a", bus.OutA, 32'h0);
    bus.FunSel = RF_LOAD;
    bus.RegSel = 4'b1000;
    bus.I      = 32'hDEADBEEF;
    @(posedge Clock);
    #1;
    checkOutput("reset_over_write", bus.OutA, 32'h0);
    bus.RegSel = 4'b0000;
    @(negedge Clock);
    Reset_N = 1'b1;
    @(posedge Clock);
    #1;
    checkAll("post_reset");

    // Load, increment wrap, decrement wrap on R1.
    applyStimulus(RF_LOAD, 4'b1000, 4'b0000, 32'hFFFFFFFF);
    checkReg("r1_ffff", SEL_R1, 32'hFFFFFFFF);
    applyStimulus(RF_INC, 4'b1000, 4'b0000, 32'h0);
    checkReg("r1_inc_wrap", SEL_R1, 32'h00000000);
    applyStimulus(RF_DEC, 4'b1000, 4'b0000, 32'h0);
    checkReg("r1_dec_wrap", SEL_R1, 32'hFFFFFFFF);

    // Partial-width operations on R2.
    applyStimulus(RF_LOAD, 4'b0100, 4'b0000, 32'hAABBCCDD);
    checkReg("r2_load", SEL_R2, 32'hAABBCCDD);
    applyStimulus(RF_LDH, 4'b0100, 4'b0000, 32'h00001234);
    checkReg("r2_ldh", SEL_R2, 32'hAABB1234);
    applyStimulus(RF_SHB, 4'b0100, 4'b0000, 32'h00000056);
    checkReg("r2_shb", SEL_R2, 32'hBB123456);
    applyStimulus(RF_SXH, 4'b0100, 4'b0000, 32'h00008001);
    checkReg("r2_sxh_neg", SEL_R2, 32'hFFFF8001);
    applyStimulus(RF_LDB, 4'b0100, 4'b0000, 32'h123456AB);
    checkReg("r2_ldb", SEL_R2, 32'h000000AB);
    applyStimulus(RF_SXH, 4'b0100, 4'b0000, 32'hABCD7FFF);
    checkReg("r2_sxh_pos", SEL_R2, 32'h00007FFF);
    applyStimulus(RF_CLR, 4'b1000, 4'b0000, 32'h5A5A5A5A);
    checkReg("r1_clr", SEL_R1, 32'h00000000);

    // Populate every register with a distinct value, then multi-select decrement.
    applyStimulus(RF_LOAD, 4'b0010, 4'b0000, 32'h5);
    applyStimulus(RF_LOAD, 4'b0001, 4'b0000, 32'h11);
    applyStimulus(RF_LOAD, 4'b0000, 4'b1000, 32'hA1);
    applyStimulus(RF_LOAD, 4'b0000, 4'b0100, 32'h9);
    applyStimulus(RF_LOAD, 4'b0000, 4'b0010, 32'hA3);
    applyStimulus(RF_LOAD, 4'b0000, 4'b0001, 32'hA4);
    expRegs[0] = 32'h0;
    expRegs[1] = 32'h00007FFF;
    expRegs[2] = 32'h5;
    expRegs[3] = 32'h11;
`ifdef OPERAND_RF_SCRATCH_EN
    expRegs[4] = 32'hA1;
    expRegs[5] = 32'h9;
    expRegs[6] = 32'hA3;
    expRegs[7] = 32'hA4;
`endif
    checkAll("populated");
    applyStimulus(RF_DEC, 4'b0010, 4'b0100, 32'hFFFF0000);
    expRegs[2] = 32'h4;
`ifdef OPERAND_RF_SCRATCH_EN
    expRegs[5] = 32'h8;
`endif
    checkAll("multi_dec");

    // No selects: nothing changes whatever FunSel says.
    applyStimulus(RF_CLR, 4'b0000, 4'b0000, 32'h0);
    checkAll("no_sel");

    // No write-to-read bypass on either port.
    @(negedge Clock);
    bus.OutASel = SEL_R4;
    bus.OutBSel = SEL_R4;
    bus.FunSel  = RF_LOAD;
    bus.RegSel  = 4'b0001;
    bus.I       = 32'h77;
    #1;
    checkOutput("nobypass_a_old", bus.OutA, 32'h11);
    checkOutput("nobypass_b_old", bus.OutB, 32'h11);
    @(posedge Clock);
    #1;
    bus.RegSel = 4'b0000;
    checkOutput("nobypass_a_new", bus.OutA, 32'h77);
    checkOutput("nobypass_b_new", bus.OutB, 32'h77);
    expRegs[3] = 32'h77;

    // ScrSel-only write: scratch bank loads when present, otherwise ignored.
    applyStimulus(RF_LOAD, 4'b0000, 4'b1111, 32'h1);
`ifdef OPERAND_RF_SCRATCH_EN
    for (int i = 4; i < 8; i++) expRegs[i] = 32'h1;
`endif
    checkAll("scr_all");

    // Same increment on two registers, one of them wrapping.
    applyStimulus(RF_LOAD, 4'b0001, 4'b0000, 32'hFFFFFFFF);
    applyStimulus(RF_INC, 4'b1001, 4'b0000, 32'h0);
    expRegs[0] = 32'h1;
    expRegs[3] = 32'h0;
    checkAll("multi_inc");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/operand_register_file.md
# operand_register_file

Eight-entry 32-bit operand store that feeds the A and B inputs of the datapath ALU. It holds four general registers R1–R4 and four scratch registers S1–S4. Every register can load, clear, increment, decrement or perform a partial-width load under a shared 3-bit function select. Two combinational read ports present any register to ALU operands A and B. ALUOut returns through the I input to close the datapath loop.

## Interface
- WIDTH, 32, register and port data width; the ALU consumes 32-bit operands.
- Clock  input  1  rising-edge clock for all registers.
- Reset_N  input  1  asynchronous, active-low reset.
- I  input  WIDTH  write data, normally ALUOut.
- FunSel  input  3  operation applied to every selected register.
- RegSel  input  4  active-high write enables, bit3=R1, bit2=R2, bit1=R3, bit0=R4.
- ScrSel  input  4  active-high write enables, bit3=S1 … bit0=S4.
- OutASel  input  3  port-A source: 000–011 = R1–R4, 100–111 = S1–S4.
- OutBSel  input  3  port-B source, same encoding as OutASel.
- OutA  output  WIDTH  ALU operand A.
- OutB  output  WIDTH  ALU operand B.

## Operation
- FunSel encoding, applied at the clock edge to each register whose select bit is 1:
  - 000: decrement, Q−1 mod 2^32.
  - 001: increment, Q+1 mod 2^32.
  - 010: load, Q←I.
  - 011: clear, Q←0.
  - 100: byte load with clear, Q←{24'b0, I[7:0]}.
  - 101: low-half load, Q←{Q[31:16], I[15:0]}.
  - 110: byte shift-in, Q←{Q[23:0], I[7:0]}.
  - 111: sign-extended half load, Q←{{16{I[15]}}, I[15:0]}.
- Unselected registers hold their value. RegSel=ScrSel=0 means no state change regardless of FunSel.
- Multiple select bits set: every selected register performs the same operation independently, each on its own Q.
- Wrap-around:
  - Increment of 0xFFFFFFFF gives 0.
  - Decrement of 0 gives 0xFFFFFFFF.
  - No carry or flag output; flags belong to the ALU.
- Read ports are purely combinational muxes of current register state. OutASel and OutBSel may name the same register.
- No write-to-read bypass. A register written at edge k shows its new value on OutA/OutB only after edge k.

## Timing
- Write latency: 1 clock. Read latency: 0, combinational from select and register state.
- Reset_N low asserts immediately, without waiting for a clock: all eight registers go to 0, so OutA=OutB=0.
- Reset_N low overrides any write in progress, including one at the same edge.
- First write takes effect at the first rising edge after Reset_N deasserts.
- FunSel, RegSel, ScrSel and I must be stable for setup before the rising edge. OutA/OutB settle within the same cycle for ALU use.

## Configuration
- OPERAND_RF_SCRATCH_EN:
  - Defined: S1–S4 are implemented as described.
  - Undefined: S1–S4 are not synthesized and ScrSel is ignored. OutASel/OutBSel values 100–111 return 0, and R1–R4 behaviour is unchanged.

## Structure
- Shared package operand_rf_pkg holds:
  - the FunSel enum: RF_DEC, RF_INC, RF_LOAD, RF_CLR, RF_LDB, RF_LDH, RF_SHB, RF_SXH;
  - the 3-bit source-select constants SEL_R1…SEL_S4;
  - WIDTH default.
- One sub-module, operand_reg: a single WIDTH-bit register with Clock, Reset_N, enable, FunSel and I, implementing the eight operations. It is instantiated 8 times (4 without the macro).
- The top level contains only the instances, select-bit fan-out and the two read muxes.

## Test plan
- Reset: drive Reset_N=0 mid-cycle after loading R1=0x12345678 -> OutA with OutASel=000 reads 0 immediately, before any clock edge.
- Load then increment: I=0xFFFFFFFF, FunSel=010, RegSel=1000; then FunSel=001 -> R1 reads 0xFFFFFFFF after edge 1 and 0x00000000 after edge 2. The next edge with FunSel=000 gives 0xFFFFFFFF.
- Partial loads:
  - R2=0xAABBCCDD, I=0x00001234.
  - FunSel=101 -> 0xAABB1234.
  - Then FunSel=110 with I=0x56 -> 0xBB123456.
  - Then FunSel=111 with I=0x8001 -> 0xFFFF8001.
- Multi-select: R3=5, S2=9, RegSel=0010, ScrSel=0100, FunSel=000 -> R3=4 and S2=8 after one edge; R1, R2, R4, S1, S3, S4 unchanged.
- No bypass and dual read: load R4 with I=0x77 while OutASel=OutBSel=011 -> both ports show the old R4 during that cycle and 0x77 after the edge.
- Macro off: OPERAND_RF_SCRATCH_EN undefined, ScrSel=1111, FunSel=010, I=0x1 -> OutASel=100 reads 0 and no R register changes.
